// File: rtl/conv_pkg.sv
// Shared definitions for the 1-D convolution stage: FSM state encoding and
// default geometry (address width, filter taps, stride) used by all blocks.
package conv_pkg;

    localparam int ADDR_W_DEF   = 5;
    localparam int FILT_LEN_DEF = 4;
    localparam int STRIDE_DEF   = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_FLUSH,
        S_DONE,
        S_WAIT_WR,
        S_ADVANCE,
        S_FIN
    } state_t;

endpackage

// File: rtl/tap_counter.sv
// Tap index counter for one convolution window.
// Ports: clk, rst (async, active-high), clr, inc -> k, term (k == FILT_LEN-1).
module tap_counter
    import conv_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] k,
    output logic              term
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
        end else if (clr) begin
            k <= '0;
        end else if (inc) begin
            k <= k + 1'b1;
        end
    end

    assign term = (k == ADDR_W'(FILT_LEN - 1));

endmodule

// File: rtl/conv_window_controller.sv
// Slides a FILT_LEN-tap window across one ifmap row, issuing MAC addresses
// per window and handshaking each result with the output write controller.
// Ports: clk, rst, start, ifmap_len, ifmap_ready, write_done ->
//        ifmap_addr, filt_addr, mac_en, acc_clr, conv_done, win_idx,
//        busy, row_done.
module conv_window_controller
    import conv_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int FILT_LEN = FILT_LEN_DEF,
    parameter int STRIDE   = STRIDE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] ifmap_len,
    input  logic              ifmap_ready,
    input  logic              write_done,
    output logic [ADDR_W-1:0] ifmap_addr,
    output logic [ADDR_W-1:0] filt_addr,
    output logic              mac_en,
    output logic              acc_clr,
    output logic              conv_done,
    output logic [ADDR_W-1:0] win_idx,
    output logic              busy,
    output logic              row_done
);

    // One extra bit so the end-of-row compare cannot wrap.
    localparam logic [ADDR_W:0] FILT_W   = (ADDR_W + 1)'(FILT_LEN);
    localparam logic [ADDR_W:0] STRIDE_W = (ADDR_W + 1)'(STRIDE);

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] k_inc;
    logic [ADDR_W:0]   nxt;
    logic              term;

    tap_counter #(
        .ADDR_W  (ADDR_W),
        .FILT_LEN(FILT_LEN)
    ) u_tap (
        .clk (clk),
        .rst (rst),
        .clr (state == S_LOAD),
        .inc (state == S_MAC),
        .k   (k),
        .term(term)
    );

    assign k_inc   = k + 1'b1;
    assign nxt     = {1'b0, base} + STRIDE_W;
    assign win_idx = base;

    // Outputs are registered from the state being entered, so they
    // track the current state exactly (Moore) without decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            base       <= '0;
            len        <= '0;
            ifmap_addr <= '0;
            filt_addr  <= '0;
            mac_en     <= 1'b0;
            acc_clr    <= 1'b0;
            conv_done  <= 1'b0;
            busy       <= 1'b0;
            row_done   <= 1'b0;
        end else begin
            ifmap_addr <= '0;
            filt_addr  <= '0;
            mac_en     <= 1'b0;
            acc_clr    <= 1'b0;
            conv_done  <= 1'b0;
            row_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len  <= ifmap_len;
                        base <= '0;
                        busy <= 1'b1;
                        if ({1'b0, ifmap_len} < FILT_W) begin
                            state    <= S_FIN;
                            row_done <= 1'b1;
                        end else begin
                            state   <= S_LOAD;
                            acc_clr <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (ifmap_ready) begin
                        state      <= S_MAC;
                        mac_en     <= 1'b1;
                        ifmap_addr <= base;
                    end else begin
                        acc_clr <= 1'b1;
                    end
                end
                S_MAC: begin
                    if (term) begin
                        state <= S_FLUSH;
                    end else begin
                        mac_en     <= 1'b1;
                        ifmap_addr <= base + k_inc;
                        filt_addr  <= k_inc;
                    end
                end
                S_FLUSH: begin
                    state     <= S_DONE;
                    conv_done <= 1'b1;
                end
                S_DONE: begin
                    state <= S_WAIT_WR;
                end
                S_WAIT_WR: begin
                    if (write_done) begin
                        state <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (nxt + FILT_W > {1'b0, len}) begin
                        state    <= S_FIN;
                        row_done <= 1'b1;
                    end else begin
                        base    <= nxt[ADDR_W-1:0];
                        state   <= S_LOAD;
                        acc_clr <= 1'b1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_controller.sv
// Scoreboard bench for conv_window_controller: expected MAC addresses and
// window indices are queued at stimulus time and popped as the DUT emits them.
module tb_conv_window_controller;
    import conv_pkg::*;

    localparam int AW = 5;
    localparam int F  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] ifmap_len = '0;
    logic          ifmap_ready = 1'b1;
    logic          wd_resp = 1'b0;
    logic          wd_spur = 1'b0;
    logic          write_done;
    logic [AW-1:0] ifmap_addr, filt_addr, win_idx;
    logic          mac_en, acc_clr, conv_done, busy, row_done;

    logic          start2 = 1'b0;
    logic [AW-1:0] len2 = '0;
    logic          ready2 = 1'b1;
    logic          wd2 = 1'b0;
    logic [AW-1:0] ifmap_addr2, filt_addr2, win_idx2;
    logic          mac_en2, acc_clr2, conv_done2, busy2, row_done2;

    assign write_done = wd_resp | wd_spur;

    always #5 clk = ~clk;

    conv_window_controller #(.ADDR_W(AW), .FILT_LEN(F), .STRIDE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .ifmap_len(ifmap_len),
        .ifmap_ready(ifmap_ready), .write_done(write_done),
        .ifmap_addr(ifmap_addr), .filt_addr(filt_addr), .mac_en(mac_en),
        .acc_clr(acc_clr), .conv_done(conv_done), .win_idx(win_idx),
        .busy(busy), .row_done(row_done)
    );

    conv_window_controller #(.ADDR_W(AW), .FILT_LEN(F), .STRIDE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .ifmap_len(len2),
        .ifmap_ready(ready2), .write_done(wd2),
        .ifmap_addr(ifmap_addr2), .filt_addr(filt_addr2), .mac_en(mac_en2),
        .acc_clr(acc_clr2), .conv_done(conv_done2), .win_idx(win_idx2),
        .busy(busy2), .row_done(row_done2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    int addr_q[$];
    int win_q[$];
    int addr2_q[$];
    int win2_q[$];
    int mac_cnt = 0, cd_cnt = 0, row_cnt = 0, clr_cnt = 0;
    int cd2_cnt = 0, wd2_cnt = 0;
    bit outstanding = 0;
    bit prev_row = 0;
    int wr_delay = 2;

    // Scoreboard for the stride-1 instance.
    always @(negedge clk) begin
        if (rst) begin
            prev_row = 0;
        end else begin
            if (mac_en) begin
                mac_cnt++;
                if (addr_q.size() == 0) check("mac_unexp", 1, 0);
                else check("mac_addr", {ifmap_addr, filt_addr}, addr_q.pop_front());
            end
            if (acc_clr) clr_cnt++;
            if (conv_done) begin
                cd_cnt++;
                check("cd_outstanding", outstanding, 0);
                outstanding = 1;
                if (win_q.size() == 0) check("cd_unexp", 1, 0);
                else check("win_idx", win_idx, win_q.pop_front());
            end
            if (prev_row) check("busy_fall", busy, 0);
            if (row_done) begin
                row_cnt++;
                check("busy_at_row_done", busy, 1);
            end
            prev_row = row_done;
        end
    end

    // Write-controller model: pulse write_done wr_delay cycles after conv_done.
    initial begin
        forever begin
            @(negedge clk);
            if (conv_done && !rst) begin
                repeat (wr_delay) @(negedge clk);
                outstanding = 0;
                wd_resp = 1'b1;
                @(negedge clk);
                wd_resp = 1'b0;
            end
        end
    end

    // Scoreboard and write model for the stride-2 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (wd2) wd2 = 1'b0;
            if (wd2_cnt > 0) begin
                wd2_cnt--;
                if (wd2_cnt == 0) wd2 = 1'b1;
            end
            if (mac_en2) begin
                if (addr2_q.size() == 0) check("s2_mac_unexp", 1, 0);
                else check("s2_mac_addr", {ifmap_addr2, filt_addr2}, addr2_q.pop_front());
            end
            if (conv_done2) begin
                cd2_cnt++;
                wd2_cnt = 2;
                if (win2_q.size() == 0) check("s2_cd_unexp", 1, 0);
                else check("s2_win_idx", win_idx2, win2_q.pop_front());
            end
        end
    end

    task automatic push_exp(input int len, input int s, input bit second);
        for (int b = 0; b + F <= len; b += s) begin
            if (second) win2_q.push_back(b);
            else win_q.push_back(b);
            for (int k = 0; k < F; k++) begin
                if (second) addr2_q.push_back(((b + k) << AW) | k);
                else addr_q.push_back(((b + k) << AW) | k);
            end
        end
    endtask

    task automatic run_row(input string tag, input int len, input int exp_cyc);
        int cyc;
        int r0;
        r0 = row_cnt;
        ifmap_len = AW'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!row_done && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 500) check({tag, "_timeout"}, 0, 1);
        check({tag, "_cycles"}, cyc, exp_cyc);
        @(negedge clk);
        check({tag, "_row_cnt"}, row_cnt - r0, 1);
        check({tag, "_q_empty"}, addr_q.size() + win_q.size(), 0);
    endtask

    initial begin
        int m0, c0, k0, r0, cyc;

        #1;
        check("rst_outs", {mac_en, acc_clr, conv_done, row_done, busy,
                           ifmap_addr, filt_addr, win_idx}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_outs", {mac_en, acc_clr, conv_done, row_done}, 0);

        // Basic row: 3 windows of 10 cycles each, then FIN.
        m0 = mac_cnt; c0 = cd_cnt; k0 = clr_cnt;
        push_exp(6, 1, 0);
        run_row("basic", 6, 3 * (4 + F + 2) + 1);
        check("basic_mac_cnt", mac_cnt - m0, 3 * F);
        check("basic_cd_cnt", cd_cnt - c0, 3);
        check("basic_clr_cnt", clr_cnt - k0, 3);

        // Short row: no windows at all.
        m0 = mac_cnt; c0 = cd_cnt;
        run_row("short", 3, 1);
        check("short_mac", mac_cnt - m0, 0);
        check("short_cd", cd_cnt - c0, 0);

        // Boundary: exactly one window.
        push_exp(F, 1, 0);
        run_row("exact", F, (4 + F + 2) + 1);

        // Stalls: ifmap_ready low for 5 extra LOAD cycles, slow write_done.
        c0 = cd_cnt; k0 = clr_cnt;
        wr_delay = 10;
        ifmap_ready = 1'b0;
        push_exp(4, 1, 0);
        fork
            begin
                repeat (6) @(negedge clk);
                ifmap_ready = 1'b1;
            end
        join_none
        run_row("stall", 4, 6 + F + 1 + 1 + 10 + 1 + 1);
        check("stall_clr_cnt", clr_cnt - k0, 6);
        check("stall_cd_cnt", cd_cnt - c0, 1);
        wr_delay = 2;

        // Spurious start / write_done during the first MAC cycle.
        c0 = cd_cnt;
        push_exp(5, 1, 0);
        fork
            begin
                repeat (2) @(negedge clk);
                start = 1'b1;
                wd_spur = 1'b1;
                @(negedge clk);
                start = 1'b0;
                wd_spur = 1'b0;
            end
        join_none
        run_row("spur", 5, 2 * (4 + F + 2) + 1);
        check("spur_cd_cnt", cd_cnt - c0, 2);

        // Stride 2 on the second instance: bases 0, 2, 4.
        push_exp(9, 2, 1);
        len2 = AW'(9);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        while (!row_done2 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 500) check("s2_timeout", 0, 1);
        check("s2_cycles", cyc, 3 * (4 + F + 2) + 1);
        check("s2_cd_cnt", cd2_cnt, 3);
        check("s2_q_empty", addr2_q.size() + win2_q.size(), 0);
        @(negedge clk);
        check("s2_busy", busy2, 0);

        // Reset mid-MAC aborts immediately.
        c0 = cd_cnt; r0 = row_cnt;
        push_exp(6, 1, 0);
        ifmap_len = AW'(6);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_mac", mac_en, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_outs", {mac_en, acc_clr, conv_done, row_done, busy,
                               ifmap_addr, filt_addr, win_idx}, 0);
        @(negedge clk);
        addr_q.delete();
        win_q.delete();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_cd", cd_cnt - c0, 0);
        check("post_rst_row", row_cnt - r0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got 0 want 1");
        $fatal(1, "watchdog expired");
    end

endmodule
